// File: rtl/pll_ce_gen_if.sv
// ---------------------------------------------------------------------------
// pll_ce_gen_if
// Bundles the configuration and enable-output signals of pll_ce_gen.
//
// Signals
//   inc      NUM_CH*ACC_W  per-channel phase increment, ch i = inc[i*ACC_W +: ACC_W]
//   phase    NUM_CH*ACC_W  per-channel start phase, loaded on entry to RUN / resync
//   ch_en    NUM_CH        per-channel run enable
//   resync   1             one-cycle pulse: reload every accumulator from phase
//   ce       NUM_CH        per-channel single-cycle clock enable (from generator)
//   running  1             high while the generator is in RUN (from generator)
//
// Modports
//   master  drives configuration, observes enables (system side)
//   slave   the generator itself
// ---------------------------------------------------------------------------
interface pll_ce_gen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32
);

  logic [NUM_CH*ACC_W-1:0] inc;
  logic [NUM_CH*ACC_W-1:0] phase;
  logic [NUM_CH-1:0]       ch_en;
  logic                    resync;
  logic [NUM_CH-1:0]       ce;
  logic                    running;

  modport master (
    output inc,
    output phase,
    output ch_en,
    output resync,
    input  ce,
    input  running
  );

  modport slave (
    input  inc,
    input  phase,
    input  ch_en,
    input  resync,
    output ce,
    output running
  );

endinterface

// File: rtl/pll_ce_gen.sv
// ---------------------------------------------------------------------------
// pll_ce_gen
// Multi-channel fractional clock-enable generator clocked by the fast PLL
// output. Each channel is a phase accumulator whose carry-out becomes a
// single-cycle enable, giving a mean rate of f_clk * inc / 2^ACC_W. All
// enables are gated by a synchronised and debounced PLL lock.
//
// Parameters
//   NUM_CH       number of enable channels (1..16)
//   ACC_W        phase-accumulator width in bits (8..48)
//   LOCK_STABLE  consecutive synchronised-lock cycles required before RUN
//   LOCK_CNT_W   debounce counter width, must be able to hold LOCK_STABLE
//
// Ports
//   clk          fast PLL clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   pll_locked   raw PLL lock, asynchronous to clk
//   bus          pll_ce_gen_if.slave: inc, phase, ch_en, resync in;
//                ce, running out
// ---------------------------------------------------------------------------
module pll_ce_gen #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_STABLE = 1024,
  parameter int LOCK_CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pll_locked,
  pll_ce_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_STABLE - 1);

  // Lock synchroniser: pll_locked is sampled only by sync1_q.
  logic sync1_q;
  logic lk_s_q;

  state_t                 state_q, state_d;
  logic [LOCK_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]       acc_q [NUM_CH];
  logic [ACC_W-1:0]       acc_d [NUM_CH];
  logic [NUM_CH-1:0]      ce_q, ce_d;
  logic                   running_q, running_d;

  // One extra bit per channel so the carry out of the add is the enable.
  logic [ACC_W:0]         sum [NUM_CH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      lk_s_q  <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_s_q  <= sync1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, bus.inc[i*ACC_W +: ACC_W]};
    end
  end

  // Next-state logic. Outside RUN the accumulators hold and ce is low.
  // Losing lock in RUN leaves immediately and clears ce at the same edge,
  // so a pulse already registered still lasts its full cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ce_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i] = acc_q[i];
    end

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_s_q) begin
          state_d = STABLE;
        end
      end

      STABLE: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          // Entry to RUN only loads phases; the first carry comes from
          // the first add after entry.
          state_d = RUN;
          cnt_d   = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = bus.phase[i*ACC_W +: ACC_W];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (bus.resync) begin
          for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = bus.phase[i*ACC_W +: ACC_W];
          end
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_en[i]) begin
              acc_d[i] = sum[i][ACC_W-1:0];
              ce_d[i]  = sum[i][ACC_W];
            end
          end
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      ce_q      <= '0;
      running_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ce_q      <= ce_d;
      running_q <= running_d;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign bus.ce      = ce_q;
  assign bus.running = running_q;

endmodule
